// File: rtl/ncpu32k_cell_pipefifo.sv
// Multi-slot pipeline FIFO with valid/ready handshakes, synchronous flush and occupancy status.
// Optional zero-latency fall-through when empty: define NCPU_PIPEFIFO_FWFT_BYPASS_EN.
module ncpu32k_cell_pipefifo #(
    parameter int DW            = 32,
    parameter int DEPTH         = 4,
    parameter int ENABLE_BYPASS = 1,
    parameter int AFULL_LVL     = DEPTH - 1,
    parameter int CW            = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic [DW-1:0] din,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] dout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] count,
    output logic          almost_full
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic pass;
    logic wr_en;
    logic rd_en;

    always_comb begin
        full  = (count == CW'(DEPTH));
        empty = (count == '0);

`ifdef NCPU_PIPEFIFO_FWFT_BYPASS_EN
        // Empty FIFO is transparent: the producer's item is presented directly
        out_valid = ~flush & (~empty | in_valid);
        dout      = empty ? din : mem[rd_ptr];
`else
        out_valid = ~flush & ~empty;
        dout      = mem[rd_ptr];
`endif

        // When full, out_valid is high, so out_ready alone guarantees a pop this cycle
        in_ready = ~flush & (~full | ((ENABLE_BYPASS != 0) & out_ready));

        push = in_valid & in_ready;
        pop  = out_valid & out_ready;

`ifdef NCPU_PIPEFIFO_FWFT_BYPASS_EN
        pass = empty & push & pop;
`else
        pass = 1'b0;
`endif

        // A passed-through item never touches storage or occupancy
        wr_en = push & ~pass;
        rd_en = pop & ~pass;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // Power-of-two depth lets the pointers wrap by plain overflow
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign almost_full = (count >= CW'(AFULL_LVL));

endmodule

// File: tb/tb_ncpu32k_cell_pipefifo.sv
// Randomised bench for ncpu32k_cell_pipefifo: bypass and non-bypass instances share stimulus
// and are each compared every cycle against a queue-based reference model.
module tb_ncpu32k_cell_pipefifo;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
    localparam int AFULL = DEPTH - 1;

`ifdef NCPU_PIPEFIFO_FWFT_BYPASS_EN
    localparam bit FWFT = 1'b1;
`else
    localparam bit FWFT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] din = '0;

    logic          in_ready_b, out_valid_b, af_b;
    logic [DW-1:0] dout_b;
    logic [CW-1:0] count_b;
    logic          in_ready_n, out_valid_n, af_n;
    logic [DW-1:0] dout_n;
    logic [CW-1:0] count_n;

    logic [DW-1:0] q_b[$];
    logic [DW-1:0] q_n[$];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ncpu32k_cell_pipefifo #(.DW(DW), .DEPTH(DEPTH), .ENABLE_BYPASS(1), .AFULL_LVL(AFULL)) u_dut_byp (
        .clk(clk), .rst_n(rst_n), .flush(flush), .din(din), .in_valid(in_valid),
        .in_ready(in_ready_b), .dout(dout_b), .out_valid(out_valid_b), .out_ready(out_ready),
        .count(count_b), .almost_full(af_b)
    );

    ncpu32k_cell_pipefifo #(.DW(DW), .DEPTH(DEPTH), .ENABLE_BYPASS(0), .AFULL_LVL(AFULL)) u_dut_nob (
        .clk(clk), .rst_n(rst_n), .flush(flush), .din(din), .in_valid(in_valid),
        .in_ready(in_ready_n), .dout(dout_n), .out_valid(out_valid_n), .out_ready(out_ready),
        .count(count_n), .almost_full(af_n)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected outputs follow directly from queue occupancy and the handshake rules
    task automatic check_side(input string side, input int sz, input logic [DW-1:0] head, input bit byp,
                              input logic ir, input logic ov, input logic [DW-1:0] dt,
                              input logic [CW-1:0] cnt, input logic af,
                              output bit push, output bit pop);
        bit exp_ov, exp_ir;
        logic [DW-1:0] exp_d;
        exp_ov = !flush && (sz != 0 || (FWFT && in_valid));
        exp_ir = !flush && (sz != DEPTH || (byp && out_ready));
        exp_d  = (sz != 0) ? head : din;
        check({side, ".out_valid"}, ov, exp_ov);
        check({side, ".in_ready"}, ir, exp_ir);
        if (exp_ov) check({side, ".dout"}, dt, exp_d);
        check({side, ".count"}, cnt, sz);
        check({side, ".almost_full"}, af, sz >= AFULL);
        push = in_valid && exp_ir;
        pop  = exp_ov && out_ready;
    endtask

    task automatic cycle(input bit fl, input bit iv, input logic [DW-1:0] d, input bit ordy);
        bit pu_b, po_b, pu_n, po_n;
        int sz_b, sz_n;
        @(negedge clk);
        flush = fl; in_valid = iv; din = d; out_ready = ordy;
        #1;
        sz_b = q_b.size();
        sz_n = q_n.size();
        check_side("byp", sz_b, (sz_b != 0) ? q_b[0] : '0, 1'b1, in_ready_b, out_valid_b, dout_b, count_b, af_b, pu_b, po_b);
        check_side("nob", sz_n, (sz_n != 0) ? q_n[0] : '0, 1'b0, in_ready_n, out_valid_n, dout_n, count_n, af_n, pu_n, po_n);
        @(posedge clk);
        if (fl) begin
            q_b.delete();
        end else if (!(FWFT && sz_b == 0 && pu_b && po_b)) begin
            if (po_b) void'(q_b.pop_front());
            if (pu_b) q_b.push_back(d);
        end
        if (fl) begin
            q_n.delete();
        end else if (!(FWFT && sz_n == 0 && pu_n && po_n)) begin
            if (po_n) void'(q_n.pop_front());
            if (pu_n) q_n.push_back(d);
        end
        #1;
        flush = 1'b0; in_valid = 1'b0; din = '0; out_ready = 1'b0;
    endtask

    initial begin
        int pv, pr;
        repeat (3) @(negedge clk);
        #1;
        check("rst.out_valid", out_valid_b, 1'b0);
        check("rst.count", count_b, 0);
        check("rst.dout", dout_b, 0);
        check("rst.almost_full", af_b, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle.in_ready_b", in_ready_b, 1'b1);
        check("idle.in_ready_n", in_ready_n, 1'b1);
        check("idle.out_valid_n", out_valid_n, 1'b0);
        check("idle.dout_n", dout_n, 0);
        check("idle.count_n", count_n, 0);

        // Fill with the consumer stalled
        cycle(0, 1, 32'h11, 0);
        cycle(0, 1, 32'h22, 0);
        cycle(0, 1, 32'h33, 0);
        #1;
        check("fill.af_at_3", af_n, 1'b1);
        cycle(0, 1, 32'h44, 0);
        #1;
        check("fill.count", count_n, 4);
        check("fill.in_ready_nob", in_ready_n, 1'b0);
        check("fill.head", dout_n, 32'h11);

        // Full + push + pop: bypass instance keeps four entries, the other only pops
        cycle(0, 1, 32'h55, 1);
        #1;
        check("fullbyp.count_b", count_b, 4);
        check("fullbyp.count_n", count_n, 3);
        check("fullbyp.head", dout_b, 32'h22);
        repeat (5) cycle(0, 0, '0, 1);
        #1;
        check("drain.out_valid", out_valid_b, 1'b0);

        // Flush with three entries and a concurrent push
        cycle(0, 1, 32'h1, 0);
        cycle(0, 1, 32'h2, 0);
        cycle(0, 1, 32'h3, 0);
        cycle(1, 1, 32'h77, 1);
        #1;
        check("flush.count", count_b, 0);
        check("flush.out_valid", out_valid_b, 1'b0);
        check("flush.in_ready", in_ready_b, 1'b1);
        cycle(0, 1, 32'h99, 0);
        #1;
        check("flush.first_out", dout_b, 32'h99);
        repeat (2) cycle(0, 0, '0, 1);

`ifdef NCPU_PIPEFIFO_FWFT_BYPASS_EN
        @(negedge clk);
        in_valid = 1'b1; din = 32'hAB; out_ready = 1'b1;
        #1;
        check("fwft.out_valid", out_valid_b, 1'b1);
        check("fwft.dout", dout_b, 32'hAB);
        @(posedge clk);
        #1;
        in_valid = 1'b0; din = '0; out_ready = 1'b0;
        #1;
        check("fwft.count_pass", count_b, 0);
        cycle(0, 1, 32'hAB, 0);
        #1;
        check("fwft.count_store", count_b, 1);
        check("fwft.dout_store", dout_b, 32'hAB);
        cycle(0, 0, '0, 1);
`endif

        for (int s = 0; s < 10; s++) begin
            pv = $urandom_range(20, 95);
            pr = $urandom_range(20, 95);
            for (int c = 0; c < 1000; c++) begin
                cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < pv,
                      $urandom, $urandom_range(0, 99) < pr);
                if (s == 5 && c == 500) begin
                    #1;
                    rst_n = 1'b0;
                    #1;
                    check("midrst.count", count_b, 0);
                    check("midrst.out_valid", out_valid_n, 1'b0);
                    check("midrst.dout", dout_b, 0);
                    q_b.delete();
                    q_n.delete();
                    @(negedge clk);
                    rst_n = 1'b1;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
